// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: HD44780-style command bytes, line base
// addresses, arbiter state encoding and the init command lookup.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_FUNC  = 8'h3C;
  localparam logic [7:0] LCD_CMD_DISP  = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;
  localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;

  localparam logic [6:0] LCD_LINE1_BASE = 7'h00;
  localparam logic [6:0] LCD_LINE2_BASE = 7'h40;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT,
    ST_IDLE,
    ST_SETADDR,
    ST_WRCHAR
  } lcd_state_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = LCD_CMD_CLEAR;
      2'd1:    init_cmd = LCD_CMD_FUNC;
      2'd2:    init_cmd = LCD_CMD_DISP;
      default: init_cmd = LCD_CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single LCD bus transfer: one setup cycle, E_WIDTH cycles of E high, then
// GAP idle cycles. RS/DATA stay stable throughout and after the transfer.
module lcd_xfer #(
  parameter int E_WIDTH = 2,
  parameter int GAP     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam logic [7:0] E_LAST = 8'(E_WIDTH);
  localparam logic [7:0] LAST   = 8'(E_WIDTH + GAP);

  logic       busy_q, busy_d;
  logic [7:0] cnt_q, cnt_d;
  logic       e_q, e_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;

  // done marks the final gap cycle so the owner can chain the next start
  // into the same edge, keeping transfers back to back.
  assign done = busy_q && (cnt_q == LAST);

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    e_d    = e_q;
    rs_d   = rs_q;
    data_d = data_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = 8'd0;
      e_d    = 1'b0;
      rs_d   = rs;
      data_d = data;
    end else if (busy_q) begin
      if (done) begin
        busy_d = 1'b0;
        e_d    = 1'b0;
      end else begin
        cnt_d = cnt_q + 8'd1;
        e_d   = (cnt_q < E_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= 8'd0;
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      e_q    <= e_d;
      rs_q   <= rs_d;
      data_q <= data_d;
    end
  end

  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Character-LCD bus sequencer and two-writer arbiter. Define LCD_ARB_RR_EN
// for round-robin arbitration; otherwise requester A has fixed priority.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int PWR_WAIT = 70,
  parameter int E_WIDTH  = 2,
  parameter int GAP      = 4,
  parameter int CLR_WAIT = 200
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       REQ_A,
  input  logic       REQ_B,
  input  logic [6:0] ADDR_A,
  input  logic [6:0] ADDR_B,
  input  logic [7:0] CHAR_A,
  input  logic [7:0] CHAR_B,
  output logic       ACK_A,
  output logic       ACK_B,
  output logic       READY,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam logic [15:0] PWR_LAST = 16'(PWR_WAIT - 1);
  localparam logic [15:0] CLR_LAST = 16'(CLR_WAIT - 1);

  lcd_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        clr_wait_q, clr_wait_d;
  logic        ready_q, ready_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic [6:0]  cur_q, cur_d;
  logic        cur_vld_q, cur_vld_d;
  logic        sel_b_q, sel_b_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  char_q, char_d;
`ifdef LCD_ARB_RR_EN
  logic        last_b_q, last_b_d;
`endif

  logic        pick_b;
  logic [6:0]  addr_sel;
  logic [7:0]  char_sel;
  logic        x_start, x_rs, x_done;
  logic [7:0]  x_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    init_idx_d = init_idx_q;
    clr_wait_d = clr_wait_q;
    ready_d    = ready_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    cur_d      = cur_q;
    cur_vld_d  = cur_vld_q;
    sel_b_d    = sel_b_q;
    addr_d     = addr_q;
    char_d     = char_q;
    x_start    = 1'b0;
    x_rs       = 1'b0;
    x_data     = 8'h00;
`ifdef LCD_ARB_RR_EN
    last_b_d   = last_b_q;
    pick_b     = REQ_B && (!REQ_A || !last_b_q);
`else
    pick_b     = !REQ_A;
`endif
    addr_sel   = pick_b ? ADDR_B : ADDR_A;
    char_sel   = pick_b ? CHAR_B : CHAR_A;

    case (state_q)
      ST_PWR: begin
        if (cnt_q == PWR_LAST) begin
          state_d    = ST_INIT;
          init_idx_d = 2'd0;
          x_start    = 1'b1;
          x_data     = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_INIT: begin
        if (clr_wait_q) begin
          if (cnt_q == CLR_LAST) begin
            clr_wait_d = 1'b0;
            init_idx_d = 2'd1;
            x_start    = 1'b1;
            x_data     = init_cmd(2'd1);
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (x_done) begin
          if (init_idx_q == 2'd3) begin
            ready_d   = 1'b1;
            cur_d     = LCD_LINE1_BASE;
            cur_vld_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (init_idx_q == 2'd0 && CLR_WAIT != 0) begin
            // The clear command needs a long settle before anything else.
            clr_wait_d = 1'b1;
            cnt_d      = 16'd0;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            x_start    = 1'b1;
            x_data     = init_cmd(init_idx_q + 2'd1);
          end
        end
      end
      ST_IDLE: begin
        // The ACK cycle itself is not a grant slot, so a requester holding
        // REQ into its ACK cycle cannot be served twice.
        if (ready_q && !ack_a_q && !ack_b_q && (REQ_A || REQ_B)) begin
          sel_b_d = pick_b;
          addr_d  = addr_sel;
          char_d  = char_sel;
`ifdef LCD_ARB_RR_EN
          last_b_d = pick_b;
`endif
          x_start = 1'b1;
          if (cur_vld_q && cur_q == addr_sel) begin
            state_d = ST_WRCHAR;
            x_rs    = 1'b1;
            x_data  = char_sel;
          end else begin
            state_d = ST_SETADDR;
            x_data  = LCD_CMD_DDRAM | {1'b0, addr_sel};
          end
        end
      end
      ST_SETADDR: begin
        if (x_done) begin
          state_d = ST_WRCHAR;
          x_start = 1'b1;
          x_rs    = 1'b1;
          x_data  = char_q;
        end
      end
      ST_WRCHAR: begin
        if (x_done) begin
          ack_a_d = !sel_b_q;
          ack_b_d = sel_b_q;
          cur_d   = addr_q + 7'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_PWR;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_PWR;
      cnt_q      <= 16'd0;
      init_idx_q <= 2'd0;
      clr_wait_q <= 1'b0;
      ready_q    <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      cur_q      <= 7'd0;
      cur_vld_q  <= 1'b0;
      sel_b_q    <= 1'b0;
`ifdef LCD_ARB_RR_EN
      last_b_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_idx_q <= init_idx_d;
      clr_wait_q <= clr_wait_d;
      ready_q    <= ready_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      cur_q      <= cur_d;
      cur_vld_q  <= cur_vld_d;
      sel_b_q    <= sel_b_d;
`ifdef LCD_ARB_RR_EN
      last_b_q   <= last_b_d;
`endif
    end
  end

  // Latched request payload is only consumed after a grant, so no reset.
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    char_q <= char_d;
  end

  lcd_xfer #(
    .E_WIDTH(E_WIDTH),
    .GAP    (GAP)
  ) u_xfer (
    .clk     (CLK),
    .rst_n   (RESETN),
    .start   (x_start),
    .rs      (x_rs),
    .data    (x_data),
    .done    (x_done),
    .lcd_e   (LCD_E),
    .lcd_rs  (LCD_RS),
    .lcd_data(LCD_DATA)
  );

  assign ACK_A  = ack_a_q;
  assign ACK_B  = ack_b_q;
  assign READY  = ready_q;
  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: timeline reference model checked every cycle,
// plus directed literal checks of init, cursor hit/miss, arbitration, reset.
module tb_lcd_bus_arbiter;

  localparam int PWR_WAIT = 70;
  localparam int E_WIDTH  = 2;
  localparam int GAP      = 4;
  localparam int CLR_WAIT = 200;
  localparam int LEN      = 1 + E_WIDTH + GAP;
  localparam int RDY_EDGE = PWR_WAIT + CLR_WAIT + 4 * LEN;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       REQ_A = 1'b0, REQ_B = 1'b0;
  logic [6:0] ADDR_A = 7'd0, ADDR_B = 7'd0;
  logic [7:0] CHAR_A = 8'd0, CHAR_B = 8'd0;
  logic       ACK_A, ACK_B, READY, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  lcd_bus_arbiter #(
    .PWR_WAIT(PWR_WAIT), .E_WIDTH(E_WIDTH), .GAP(GAP), .CLR_WAIT(CLR_WAIT)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .REQ_A(REQ_A), .REQ_B(REQ_B),
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
    .CHAR_A(CHAR_A), .CHAR_B(CHAR_B),
    .ACK_A(ACK_A), .ACK_B(ACK_B), .READY(READY),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a list of scheduled bus transfers (edge at which the
  // setup cycle becomes visible), a pending ACK edge and the earliest grant edge.
  typedef struct { int st; bit rs; logic [7:0] d; } xf_t;
  xf_t        xq[$];
  int         k = 0;
  int         ack_edge = -1;
  bit         ack_is_b = 1'b0;
  int         free_edge = RDY_EDGE + 1;
  logic [6:0] m_cur = 7'd0;
  bit         m_last_b = 1'b1;

  logic [8:0] trace[$];
  bit         order[$];
  bit         e_prev = 1'b0;

  function automatic logic [8:0] tr(input int i);
    return (trace.size() > i) ? trace[i] : 9'h1FF;
  endfunction

  function automatic int odr(input int i);
    return (order.size() > i) ? int'(order[i]) : 9;
  endfunction

  always @(posedge CLK) begin
    bit ra, rb, pb, ee, ers;
    logic [6:0] aa, ab, ad;
    logic [7:0] ca, cb, ch, ed;
    ra = REQ_A; rb = REQ_B; aa = ADDR_A; ab = ADDR_B; ca = CHAR_A; cb = CHAR_B;
    if (!RESETN) begin
      k = 0;
      xq.delete();
      xq.push_back('{PWR_WAIT, 1'b0, 8'h01});
      xq.push_back('{PWR_WAIT + LEN + CLR_WAIT, 1'b0, 8'h3C});
      xq.push_back('{PWR_WAIT + 2 * LEN + CLR_WAIT, 1'b0, 8'h0C});
      xq.push_back('{PWR_WAIT + 3 * LEN + CLR_WAIT, 1'b0, 8'h06});
      ack_edge = -1;
      free_edge = RDY_EDGE + 1;
      m_cur = 7'h00;
      m_last_b = 1'b1;
    end else begin
      k++;
      if (k >= free_edge && (ra || rb)) begin
`ifdef LCD_ARB_RR_EN
        pb = rb && (!ra || !m_last_b);
`else
        pb = !ra;
`endif
        m_last_b = pb;
        ad = pb ? ab : aa;
        ch = pb ? cb : ca;
        if (ad == m_cur) begin
          xq.push_back('{k, 1'b1, ch});
          ack_edge = k + LEN;
        end else begin
          xq.push_back('{k, 1'b0, {1'b1, ad}});
          xq.push_back('{k + LEN, 1'b1, ch});
          ack_edge = k + 2 * LEN;
        end
        ack_is_b = pb;
        m_cur = ad + 7'd1;
        free_edge = ack_edge + 2;
      end
    end
    ee = 1'b0; ers = 1'b0; ed = 8'h00;
    for (int i = xq.size() - 1; i >= 0; i--) begin
      if (xq[i].st <= k) begin
        ee  = (k - xq[i].st >= 1) && (k - xq[i].st <= E_WIDTH);
        ers = xq[i].rs;
        ed  = xq[i].d;
        break;
      end
    end
    #1;
    chk("LCD_E", LCD_E, ee);
    chk("LCD_RS", LCD_RS, ers);
    chk("LCD_DATA", LCD_DATA, ed);
    chk("LCD_RW", LCD_RW, 0);
    chk("READY", READY, (k >= RDY_EDGE));
    chk("ACK_A", ACK_A, (k == ack_edge && !ack_is_b));
    chk("ACK_B", ACK_B, (k == ack_edge && ack_is_b));
    if (LCD_E && !e_prev) trace.push_back({LCD_RS, LCD_DATA});
    e_prev = LCD_E;
    if (ACK_A) order.push_back(1'b0);
    if (ACK_B) order.push_back(1'b1);
  end

  // Raise a request at the current negedge and wait for its ACK (bounded).
  task automatic xact(input bit side, input logic [6:0] a, input logic [7:0] c, output int lat);
    if (side) begin REQ_B = 1'b1; ADDR_B = a; CHAR_B = c; end
    else begin REQ_A = 1'b1; ADDR_A = a; CHAR_A = c; end
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!(side ? ACK_B : ACK_A) && lat < 600);
    if (side) chk("ack_b_seen", ACK_B, 1);
    else chk("ack_a_seen", ACK_A, 1);
  endtask

  task automatic do_a(input logic [6:0] a, input logic [7:0] c, output int lat);
    @(negedge CLK);
    xact(1'b0, a, c, lat);
    REQ_A = 1'b0;
  endtask

  task automatic drv(input bit side, input int n, input int gapmax, input bit rnd_addr);
    int lat, gap;
    logic [6:0] a;
    @(negedge CLK);
    for (int i = 0; i < n; i++) begin
      if (!rnd_addr) a = side ? 7'h40 + 7'(i) : 7'h00 + 7'(i);
      else if ($urandom_range(0, 2) == 0) a = 7'($urandom);
      else a = ($urandom_range(0, 1) ? 7'h40 : 7'h00) + 7'($urandom_range(0, 3));
      xact(side, a, 8'($urandom), lat);
      gap = $urandom_range(0, gapmax);
      if (gap != 0 || i == n - 1) begin
        if (side) REQ_B = 1'b0; else REQ_A = 1'b0;
        repeat (gap) @(negedge CLK);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_E"}, LCD_E, 0);
    chk({tag, "_RS"}, LCD_RS, 0);
    chk({tag, "_RW"}, LCD_RW, 0);
    chk({tag, "_DATA"}, LCD_DATA, 0);
    chk({tag, "_ACKA"}, ACK_A, 0);
    chk({tag, "_ACKB"}, ACK_B, 0);
    chk({tag, "_READY"}, READY, 0);
  endtask

  initial begin
    int n, lat;
    bit found;
    repeat (3) @(negedge CLK);
    chk_reset_vals("rst0");

    // Power-up sequence and READY timing.
    trace.delete();
    RESETN = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!READY && n < 1000);
    chk("ready_lat", n, 298);
    chk("init_cmd0", tr(0), 9'h001);
    chk("init_cmd1", tr(1), 9'h03C);
    chk("init_cmd2", tr(2), 9'h00C);
    chk("init_cmd3", tr(3), 9'h006);
    chk("init_cnt", trace.size(), 4);

    // Cursor hit at 0x00 after init.
    trace.delete();
    do_a(7'h00, "T", lat);
    chk("hit_lat", lat, 8);
    chk("hit_cnt", trace.size(), 1);
    chk("hit_data", tr(0), {1'b1, 8'h54});

    // Cursor miss to line 2.
    trace.delete();
    do_a(7'h40, "A", lat);
    chk("miss_lat", lat, 15);
    chk("miss_cmd", tr(0), 9'h0C0);
    chk("miss_data", tr(1), {1'b1, 8'h41});

    // Simultaneous requests held for four transfers each.
    order.delete();
    fork
      drv(1'b0, 4, 0, 1'b0);
      drv(1'b1, 4, 0, 1'b0);
    join
    chk("order0", odr(0), 0);
`ifdef LCD_ARB_RR_EN
    chk("order1", odr(1), 1);
    chk("order2", odr(2), 0);
    chk("order3", odr(3), 1);
`else
    chk("order1", odr(1), 0);
    chk("order2", odr(2), 0);
    chk("order3", odr(3), 0);
`endif
    chk("order_cnt", order.size(), 8);

    // Randomised traffic from both writers.
    fork
      drv(1'b0, 15, 4, 1'b1);
      drv(1'b1, 15, 4, 1'b1);
    join
    repeat (3) @(negedge CLK);

    // Reset in the middle of a character write.
    @(negedge CLK);
    REQ_A = 1'b1; ADDR_A = 7'h05; CHAR_A = 8'h52;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK);
      found = LCD_E && LCD_RS;
    end
    chk("wrchar_seen", found, 1);
    RESETN = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!ACK_A && n < 1000);
    chk("rst_ack_lat", n, RDY_EDGE + 1 + 2 * LEN);
    chk("rst_ack_ready", READY, 1);
    REQ_A = 1'b0;

    // Cursor wrap from 0x7F to 0x00.
    do_a(7'h7F, "x", lat);
    chk("wrap_miss_lat", lat, 15);
    trace.delete();
    do_a(7'h00, "y", lat);
    chk("wrap_hit_lat", lat, 8);
    chk("wrap_hit_cnt", trace.size(), 1);
    chk("wrap_hit_data", tr(0), {1'b1, 8'h79});

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
